// File: rtl/aes_result_checker.sv
// ---------------------------------------------------------------------------
// aes_result_checker
//
// Post-halt checker that sits downstream of the CPU/DMEM pair. Once the CPU
// raises halted, it walks the plaintext region and the decrypted region one
// word at a time and compares them byte by byte. It keeps a count of the
// differing bytes and the offset of the first one. After that it streams the
// low DUMP_BYTES of DMEM out one byte at a time over a valid/ready port. At
// the end it raises a sticky done flag together with the pass/fail verdict.
//
// Ports
//   clk_i              rising-edge clock
//   reset_i            synchronous, active-high reset
//   halted_i           CPU halt flag (level); sampled only while idle
//   mem_addr_o  [31:0] word-aligned DMEM read address
//   mem_re_o           DMEM read strobe
//   mem_rdata_i [31:0] DMEM read data, combinational from mem_addr_o;
//                      byte addr+k sits in bits [8k+7:8k]
//   dump_data_o  [7:0] streamed DMEM byte
//   dump_valid_o       dump_data_o is valid
//   dump_ready_i       sink accepts the byte when valid && ready
//   done_o             check and dump complete (sticky until reset)
//   pass_o             verdict; meaningful only while done_o = 1
//   mismatch_count_o   number of differing bytes (0..NBYTES)
//   first_mismatch_o   lowest differing byte offset, 5'd31 when none
// ---------------------------------------------------------------------------
module aes_result_checker #(
    parameter logic [31:0] PT_BASE    = 32'h00,
    parameter logic [31:0] DEC_BASE   = 32'h30,
    parameter int          NBYTES     = 16,
    parameter int          DUMP_BYTES = 64
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        halted_i,
    output logic [31:0] mem_addr_o,
    output logic        mem_re_o,
    input  logic [31:0] mem_rdata_i,
    output logic [7:0]  dump_data_o,
    output logic        dump_valid_o,
    input  logic        dump_ready_i,
    output logic        done_o,
    output logic        pass_o,
    output logic [4:0]  mismatch_count_o,
    output logic [4:0]  first_mismatch_o
);

    // NBYTES is at most 16, so the compare covers at most four words and a
    // two-bit word index is enough.
    localparam logic [1:0]  LAST_WORD   = 2'(NBYTES / 4 - 1);
    localparam logic [31:0] LAST_BYTE   = 32'(DUMP_BYTES - 1);
    localparam logic [4:0]  NO_MISMATCH = 5'd31;

    typedef enum logic [2:0] {
        IDLE,
        RD_PT,
        RD_DEC,
        RD_DUMP,
        SEND,
        DONE
    } state_t;

    state_t      state_q;
    logic [31:0] memAddr_q;
    logic        memRe_q;
    logic [7:0]  dumpData_q;
    logic        dumpValid_q;
    logic        done_q;
    logic        pass_q;
    logic [4:0]  mismatchCount_q;
    logic [4:0]  firstMismatch_q;
    logic        nonzero_q;
    logic [1:0]  wordIdx_q;
    logic [31:0] byteIdx_q;
    logic [31:0] ptWord_q;

    logic [2:0]  wordMismatches;
    logic [1:0]  firstK;
    logic [4:0]  mismatchCount_d;
    logic [4:0]  firstMismatch_d;
    logic        nonzero_d;
    logic [1:0]  nextWordIdx;
    logic [31:0] nextByteIdx;
    logic [7:0]  dumpByte_d;

    // Compare the latched plaintext word against the decrypted word that is
    // on mem_rdata_i during RD_DEC. Scanning from the top byte down means the
    // last hit recorded is the lowest differing byte. The first-mismatch
    // register only moves while it still holds the "none" marker, which is
    // safe because a real offset never exceeds 15.
    always_comb begin
        wordMismatches = '0;
        firstK         = '0;
        for (int k = 3; k >= 0; k--) begin
            if (ptWord_q[8*k +: 8] != mem_rdata_i[8*k +: 8]) begin
                wordMismatches = wordMismatches + 3'd1;
                firstK         = 2'(k);
            end
        end
        mismatchCount_d = mismatchCount_q + {2'b00, wordMismatches};
        firstMismatch_d = firstMismatch_q;
        if ((firstMismatch_q == NO_MISMATCH) && (wordMismatches != 3'd0)) begin
            firstMismatch_d = {1'b0, wordIdx_q, firstK};
        end
        nonzero_d   = nonzero_q | (ptWord_q != 32'd0);
        nextWordIdx = wordIdx_q + 2'd1;
        nextByteIdx = byteIdx_q + 32'd1;
    end

    // Pick the byte addressed by the dump index out of the word currently
    // being read.
    always_comb begin
        dumpByte_d = mem_rdata_i[7:0];
        case (byteIdx_q[1:0])
            2'd0: dumpByte_d = mem_rdata_i[7:0];
            2'd1: dumpByte_d = mem_rdata_i[15:8];
            2'd2: dumpByte_d = mem_rdata_i[23:16];
            2'd3: dumpByte_d = mem_rdata_i[31:24];
            default: dumpByte_d = mem_rdata_i[7:0];
        endcase
    end

    // Main sequencer. Because DMEM answers combinationally, the address and
    // strobe for each read state are loaded on the edge that enters that
    // state, so the data is already valid while the state is current.
    // Once the run has started, halted is not looked at again until reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q         <= IDLE;
            memAddr_q       <= 32'd0;
            memRe_q         <= 1'b0;
            dumpData_q      <= 8'd0;
            dumpValid_q     <= 1'b0;
            done_q          <= 1'b0;
            pass_q          <= 1'b0;
            mismatchCount_q <= 5'd0;
            firstMismatch_q <= NO_MISMATCH;
            nonzero_q       <= 1'b0;
            wordIdx_q       <= 2'd0;
            byteIdx_q       <= 32'd0;
            ptWord_q        <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (halted_i) begin
                        state_q   <= RD_PT;
                        wordIdx_q <= 2'd0;
                        memAddr_q <= PT_BASE;
                        memRe_q   <= 1'b1;
                    end
                end

                RD_PT: begin
                    ptWord_q  <= mem_rdata_i;
                    memAddr_q <= DEC_BASE + {28'd0, wordIdx_q, 2'b00};
                    state_q   <= RD_DEC;
                end

                RD_DEC: begin
                    mismatchCount_q <= mismatchCount_d;
                    firstMismatch_q <= firstMismatch_d;
                    nonzero_q       <= nonzero_d;
                    if (wordIdx_q == LAST_WORD) begin
                        byteIdx_q <= 32'd0;
                        memAddr_q <= 32'd0;
                        state_q   <= RD_DUMP;
                    end else begin
                        wordIdx_q <= nextWordIdx;
                        memAddr_q <= PT_BASE + {28'd0, nextWordIdx, 2'b00};
                        state_q   <= RD_PT;
                    end
                end

                RD_DUMP: begin
                    dumpData_q  <= dumpByte_d;
                    dumpValid_q <= 1'b1;
                    memRe_q     <= 1'b0;
                    state_q     <= SEND;
                end

                // The byte stays on the port until the sink takes it. The next
                // read is set up on the accepting edge, so every byte costs at
                // least two cycles.
                SEND: begin
                    if (dump_ready_i) begin
                        dumpValid_q <= 1'b0;
                        if (byteIdx_q == LAST_BYTE) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            pass_q  <= (mismatchCount_q == 5'd0) && nonzero_q;
                        end else begin
                            byteIdx_q <= nextByteIdx;
                            memAddr_q <= {nextByteIdx[31:2], 2'b00};
                            memRe_q   <= 1'b1;
                            state_q   <= RD_DUMP;
                        end
                    end
                end

                DONE: begin
                    state_q <= DONE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_addr_o       = memAddr_q;
    assign mem_re_o         = memRe_q;
    assign dump_data_o      = dumpData_q;
    assign dump_valid_o     = dumpValid_q;
    assign done_o           = done_q;
    assign pass_o           = pass_q;
    assign mismatch_count_o = mismatchCount_q;
    assign first_mismatch_o = firstMismatch_q;

endmodule

// File: tb/tb_aes_result_checker.sv
// ---------------------------------------------------------------------------
// tb_aes_result_checker
//
// Directed bench for aes_result_checker. A 64-byte DMEM array answers reads
// combinationally. Each scenario loads an image, releases halted and follows
// the byte stream. It then checks the final verdict against hand-worked
// values.
// ---------------------------------------------------------------------------
module tb_aes_result_checker;

    logic        clk;
    logic        reset;
    logic        halted;
    logic [31:0] mem_addr;
    logic        mem_re;
    logic [31:0] mem_rdata;
    logic [7:0]  dump_data;
    logic        dump_valid;
    logic        dump_ready;
    logic        done;
    logic        pass;
    logic [4:0]  mismatch_count;
    logic [4:0]  first_mismatch;

    logic [7:0]  mem [0:63];

    int checks;
    int errors;

    aes_result_checker dut (
        .clk_i            (clk),
        .reset_i          (reset),
        .halted_i         (halted),
        .mem_addr_o       (mem_addr),
        .mem_re_o         (mem_re),
        .mem_rdata_i      (mem_rdata),
        .dump_data_o      (dump_data),
        .dump_valid_o     (dump_valid),
        .dump_ready_i     (dump_ready),
        .done_o           (done),
        .pass_o           (pass),
        .mismatch_count_o (mismatch_count),
        .first_mismatch_o (first_mismatch)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational DMEM read port, little-endian within the word.
    always_comb begin
        logic [5:0] base;
        base      = {mem_addr[5:2], 2'b00};
        mem_rdata = {mem[base + 6'd3], mem[base + 6'd2], mem[base + 6'd1], mem[base]};
    end

    // Drive every DUT input at once.
    task automatic applyStimulus(input logic h, input logic r, input logic rdy);
        halted     = h;
        reset      = r;
        dump_ready = rdy;
    endtask

    // One comparison: count it, and report it if it does not hold.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Every output must sit at its reset value.
    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, ".memAddr"}, mem_addr, 32'd0);
        checkOutput({tag, ".memRe"}, {31'd0, mem_re}, 32'd0);
        checkOutput({tag, ".dumpData"}, {24'd0, dump_data}, 32'd0);
        checkOutput({tag, ".dumpValid"}, {31'd0, dump_valid}, 32'd0);
        checkOutput({tag, ".done"}, {31'd0, done}, 32'd0);
        checkOutput({tag, ".pass"}, {31'd0, pass}, 32'd0);
        checkOutput({tag, ".mmCount"}, {27'd0, mismatch_count}, 32'd0);
        checkOutput({tag, ".firstMm"}, {27'd0, first_mismatch}, 32'd31);
    endtask

    // Final verdict once the dump has finished.
    task automatic checkResult(input string tag, input logic expPass,
                               input logic [4:0] expCount, input logic [4:0] expFirst);
        checkOutput({tag, ".done"}, {31'd0, done}, 32'd1);
        checkOutput({tag, ".pass"}, {31'd0, pass}, {31'd0, expPass});
        checkOutput({tag, ".mmCount"}, {27'd0, mismatch_count}, {27'd0, expCount});
        checkOutput({tag, ".firstMm"}, {27'd0, first_mismatch}, {27'd0, expFirst});
        checkOutput({tag, ".validLow"}, {31'd0, dump_valid}, 32'd0);
        checkOutput({tag, ".memReLow"}, {31'd0, mem_re}, 32'd0);
    endtask

    // Image kinds: 0 = ascending plaintext with a matching copy at 0x30,
    // 1 = all zero, 2 = plaintext 00..0F with an inverted copy at 0x30.
    task automatic loadImage(input int kind);
        for (int i = 0; i < 64; i++) begin
            case (kind)
                0: begin
                    if (i < 16)      mem[i] = 8'(i * 17);
                    else if (i < 48) mem[i] = 8'(i) ^ 8'h5A;
                    else             mem[i] = mem[i - 48];
                end
                1: mem[i] = 8'h00;
                default: begin
                    if (i < 48) mem[i] = 8'(i);
                    else        mem[i] = ~mem[i - 48];
                end
            endcase
        end
    endtask

    // Follow the byte stream with the given ready duty (percent). Each valid
    // cycle must present the next expected byte, which also catches data that
    // changes while stalled. Returns after 64 accepted bytes plus one cycle,
    // or when the cycle budget runs out.
    task automatic runDump(input string tag, input int duty);
        int idx;
        int cycles;
        idx    = 0;
        cycles = 0;
        while (idx < 64 && cycles < 5000) begin
            @(negedge clk);
            cycles++;
            dump_ready = (duty >= 100) ? 1'b1 : ($urandom_range(99) < duty);
            if (dump_valid) begin
                checkOutput({tag, ".byte"}, {24'd0, dump_data}, {24'd0, mem[idx]});
                if (dump_ready) idx++;
            end
        end
        checkOutput({tag, ".byteCount"}, idx, 64);
        @(negedge clk);
        dump_ready = 1'b1;
    endtask

    initial begin
        int idx;
        int cycles;
        checks = 0;
        errors = 0;

        // Reset with halted low, then idle without a halt.
        loadImage(0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        checkResetOutputs("reset");
        applyStimulus(1'b0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        checkOutput("idle.memRe", {31'd0, mem_re}, 32'd0);

        // 1: identical regions, sink always ready.
        $display("[TB] test 1: matching regions");
        halted = 1'b1;
        @(negedge clk);
        checkOutput("t1.rdPtRe", {31'd0, mem_re}, 32'd1);
        checkOutput("t1.rdPtAddr", mem_addr, 32'h00);
        @(negedge clk);
        checkOutput("t1.rdDecAddr", mem_addr, 32'h30);
        @(negedge clk);
        checkOutput("t1.rdPt1Addr", mem_addr, 32'h04);
        runDump("t1", 100);
        checkResult("t1", 1'b1, 5'd0, 5'd31);

        // 2: byte 0x35 flipped.
        $display("[TB] test 2: one flipped byte");
        applyStimulus(1'b0, 1'b1, 1'b1);
        loadImage(0);
        mem[53] = mem[53] ^ 8'hFF;
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b1);
        runDump("t2", 100);
        checkResult("t2", 1'b0, 5'd1, 5'd5);

        // 3: all zero memory matches but the plaintext is empty.
        $display("[TB] test 3: all-zero memory");
        applyStimulus(1'b0, 1'b1, 1'b1);
        loadImage(1);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b1);
        runDump("t3", 100);
        checkResult("t3", 1'b0, 5'd0, 5'd31);

        // 4: ready at 30 percent duty.
        $display("[TB] test 4: throttled sink");
        applyStimulus(1'b0, 1'b1, 1'b0);
        loadImage(0);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b0);
        runDump("t4", 30);
        checkResult("t4", 1'b1, 5'd0, 5'd31);

        // 5: reset pulse while the 20th byte is on the port.
        $display("[TB] test 5: reset mid-dump");
        applyStimulus(1'b0, 1'b1, 1'b1);
        loadImage(0);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b1);
        idx    = 0;
        cycles = 0;
        while (cycles < 1000) begin
            @(negedge clk);
            cycles++;
            if (dump_valid) begin
                if (idx == 19) break;
                idx++;
            end
        end
        checkOutput("t5.reachedByte19", idx, 19);
        checkOutput("t5.byte19", {24'd0, dump_data}, {24'd0, mem[19]});
        applyStimulus(1'b1, 1'b1, 1'b0);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkResetOutputs("t5.afterReset");
        runDump("t5", 100);
        checkResult("t5", 1'b1, 5'd0, 5'd31);

        // 6: halted held through reset; every compared byte differs.
        $display("[TB] test 6: halted during reset, full mismatch");
        loadImage(2);
        applyStimulus(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("t6.noReadInReset", {31'd0, mem_re}, 32'd0);
        end
        applyStimulus(1'b1, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("t6.firstReadRe", {31'd0, mem_re}, 32'd1);
        checkOutput("t6.firstReadAddr", mem_addr, 32'h00);
        repeat (7) @(negedge clk);
        checkOutput("t6.countAfter3Words", {27'd0, mismatch_count}, 32'd12);
        @(negedge clk);
        checkOutput("t6.countAtLatency", {27'd0, mismatch_count}, 32'd16);
        checkOutput("t6.firstAtLatency", {27'd0, first_mismatch}, 32'd0);
        runDump("t6", 100);
        checkResult("t6", 1'b0, 5'd16, 5'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
